// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the IF/ME pipeline stages, the arbiter and the shared single-port memory.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              me_req;
    logic              me_we;
    logic [ADDR_W-1:0] me_addr;
    logic [DATA_W-1:0] me_wdata;
    logic [DATA_W-1:0] me_rdata;
    logic              me_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall;

    modport master (
        output if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata,
        input  if_rdata, if_ready, me_rdata, me_ready, mem_en, mem_we, mem_addr, mem_wdata,
               pipe_stall
    );

    modport slave (
        input  if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata,
        output if_rdata, if_ready, me_rdata, me_ready, mem_en, mem_we, mem_addr, mem_wdata,
               pipe_stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (ME), one access at a time.
// ME wins ties unless fetch has lost STARVE_MAX arbitrations in a row.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LAT        = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 2);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              own_me_q, own_me_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] me_rdata_q, me_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              me_ready_q, me_ready_d;
    logic              any_req, starved, grant_me, is_store;

    assign any_req  = bus.if_req | bus.me_req;
    assign starved  = (starve_q == SW'(STARVE_MAX));
    assign grant_me = bus.me_req & ~(bus.if_req & starved);
    assign is_store = grant_me & bus.me_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        own_me_d    = own_me_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        if_ready_d  = 1'b0;
        me_ready_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    own_me_d   = grant_me;
                    we_d       = is_store;
                    mem_en_d   = 1'b1;
                    mem_we_d   = is_store;
                    mem_addr_d = grant_me ? bus.me_addr : bus.if_addr;
                    if (grant_me) mem_wdata_d = bus.me_wdata;
                    // Stores finish after the strobe; loads wait out the read latency.
                    cnt_d = is_store ? '0 : 3'(LAT);
                    if (!grant_me || !bus.if_req) begin
                        starve_d = '0;
                    end else if (!starved) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (own_me_q) me_rdata_d = bus.mem_rdata;
                        else          if_rdata_d = bus.mem_rdata;
                    end
                    if_ready_d = ~own_me_q;
                    me_ready_d = own_me_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone:  begin end
            default: begin end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            starve_q    <= '0;
            own_me_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            me_ready_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            own_me_q    <= own_me_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
            if_ready_q  <= if_ready_d;
            me_ready_q  <= me_ready_d;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.me_rdata   = me_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.me_ready   = me_ready_q;
    // Low in the ready cycle so the pipeline registers advance exactly then.
    assign bus.pipe_stall = (bus.if_req & ~if_ready_q) | (bus.me_req & ~me_ready_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: table of single accesses, directed corner sequences,
// then random IF/ME traffic against a transaction-timeline reference model.
module tb_unified_mem_arbiter;
    localparam int unsigned LAT        = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct {
        logic        is_me;
        logic        we;
        logic        pre;       // preload memory at addr with data before a read
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_lat;
        logic [31:0] exp_rdata; // owner's rdata register after the ready pulse
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   passed;
    int   rd_due;
    logic [31:0] rd_val;
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .LAT       (LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    endtask

    // Advance one cycle and play the memory: read data is valid only LAT cycles after mem_en.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                env_mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                rd_due = cyc + int'(LAT);
                rd_val = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr]
                                                      : fill(bus.mem_addr);
            end
        end
        bus.mem_rdata = (cyc == rd_due) ? rd_val : $urandom();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_me_rdata", bus.me_rdata, 32'h0);
        chk("rst_if_ready", bus.if_ready, 32'h0);
        chk("rst_me_ready", bus.me_ready, 32'h0);
        chk("rst_mem_en", bus.mem_en, 32'h0);
        chk("rst_mem_we", bus.mem_we, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    endtask

    // One access from an idle arbiter; the request is raised in the current cycle.
    task automatic run_txn(input vec_t v);
        int   lat;
        int   n_en;
        logic rdy;
        logic other;
        if (v.pre) env_mem[v.addr] = v.data;
        bus.if_addr  = v.addr;
        bus.me_addr  = v.addr;
        bus.me_we    = v.we;
        bus.me_wdata = v.data;
        bus.if_req   = ~v.is_me;
        bus.me_req   = v.is_me;
        lat  = -1;
        n_en = 0;
        #1 chk("txn_stall_req", bus.pipe_stall, 32'h1);
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            step();
            if (bus.mem_en) begin
                n_en++;
                chk("txn_en_cycle", i, 32'd1);
                chk("txn_mem_addr", bus.mem_addr, v.addr);
                chk("txn_mem_we", bus.mem_we, v.we);
                if (v.we) chk("txn_mem_wdata", bus.mem_wdata, v.data);
            end
            rdy   = v.is_me ? bus.me_ready : bus.if_ready;
            other = v.is_me ? bus.if_ready : bus.me_ready;
            chk("txn_other_ready", other, 32'h0);
            if (rdy) begin
                lat = i;
                chk("txn_stall_ready", bus.pipe_stall, 32'h0);
            end else begin
                chk("txn_stall_wait", bus.pipe_stall, 32'h1);
            end
        end
        chk("txn_latency", lat, v.exp_lat);
        chk("txn_rdata", v.is_me ? bus.me_rdata : bus.if_rdata, v.exp_rdata);
        chk("txn_en_count", n_en, 32'd1);
        bus.if_req = 1'b0;
        bus.me_req = 1'b0;
        step();
    endtask

    vec_t        vecs [7];
    vec_t        v_after_rst;
    int          t0, me_rdy_at, if_en_at, if_rdy_at, n_grant, stray;
    logic        grant_seq [10];
    int          n_rdy, consec, prev_en;
    int          en_at [3];
    int          rdy_at [3];
    logic [31:0] rd_got [3];
    logic [31:0] t6_addr [3];
    logic [31:0] t6_data [3];
    // reference model state for the random phase
    int          k, free_at, en_cyc, rdy_cyc, starve;
    logic        t_me, t_we, if_pend, me_pend, e_en, e_if_rdy, e_me_rdy;
    logic [31:0] t_addr, t_wdata, t_rdata, e_if_rd, e_me_rd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h4,  32'h2002000A, 4, 32'h2002000A};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,        4, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, 2, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h8,  32'hCAFEF00D, 4, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h24, 32'h0BADC0DE, 4, 32'h0BADC0DE};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0,        4, 32'h12345678};
        v_after_rst = '{1'b0, 1'b0, 1'b1, 32'h4, 32'h2002000A, 4, 32'h2002000A};

        total = 0; passed = 0; cyc = 0; rd_due = -1;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.me_req = 1'b0; bus.me_we = 1'b0; bus.me_addr = '0; bus.me_wdata = '0;
        bus.mem_rdata = '0;

        // reset state
        step(); step();
        chk_reset_outputs();
        #2 rst = 1'b1;
        step();
        chk("idle_stall", bus.pipe_stall, 32'h0);

        // single accesses from the table
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // both requesters rise together: ME first, then IF
        bus.if_addr = 32'h8;  bus.if_req = 1'b1;
        bus.me_addr = 32'h24; bus.me_we = 1'b0; bus.me_req = 1'b1;
        t0 = cyc; me_rdy_at = -1; if_en_at = -1; if_rdy_at = -1;
        for (int i = 0; i < 20 && if_rdy_at < 0; i++) begin
            step();
            if (bus.mem_en && bus.mem_addr == 32'h8 && if_en_at < 0) if_en_at = cyc - t0;
            if (bus.me_ready) begin me_rdy_at = cyc - t0; bus.me_req = 1'b0; end
            if (bus.if_ready) begin if_rdy_at = cyc - t0; bus.if_req = 1'b0; end
        end
        chk("both_me_ready", me_rdy_at, 32'd4);
        chk("both_if_en", if_en_at, 32'd6);
        chk("both_if_ready", if_rdy_at, 32'd9);
        chk("both_me_rdata", bus.me_rdata, 32'h0BADC0DE);
        chk("both_if_rdata", bus.if_rdata, 32'hCAFEF00D);
        step();

        // both held continuously: IF forced through after STARVE_MAX ME grants
        bus.if_addr = 32'h100; bus.me_addr = 32'h200; bus.me_we = 1'b0;
        bus.if_req = 1'b1; bus.me_req = 1'b1;
        n_grant = 0;
        for (int i = 0; i < 10; i++) grant_seq[i] = 1'bx;
        for (int i = 0; i < 80 && n_grant < 10; i++) begin
            step();
            if (bus.mem_en) begin
                grant_seq[n_grant] = (bus.mem_addr == 32'h200);
                n_grant++;
            end
        end
        bus.if_req = 1'b0; bus.me_req = 1'b0;
        chk("starve_grants", n_grant, 32'd10);
        for (int g = 0; g < 10; g++) chk("starve_order", grant_seq[g], (g % 5) != 4);
        for (int i = 0; i < 8; i++) step();

        // asynchronous reset while an access is in flight
        bus.if_addr = 32'h44; bus.if_req = 1'b1;
        step(); step();
        #2 rst = 1'b0;
        #1 chk_reset_outputs();
        bus.if_req = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            stray += int'(bus.if_ready) + int'(bus.me_ready) + int'(bus.mem_en);
        end
        chk("rst_no_stray", stray, 32'd0);
        run_txn(v_after_rst);

        // IF held over three reads
        t6_addr[0] = 32'h8;         t6_addr[1] = 32'h4;         t6_addr[2] = 32'h24;
        t6_data[0] = 32'hCAFEF00D;  t6_data[1] = 32'h2002000A;  t6_data[2] = 32'h0BADC0DE;
        for (int i = 0; i < 3; i++) begin en_at[i] = 0; rdy_at[i] = 0; rd_got[i] = '0; end
        n_rdy = 0; consec = 0; prev_en = -10;
        bus.if_addr = t6_addr[0]; bus.if_req = 1'b1;
        for (int i = 0; i < 40 && n_rdy < 3; i++) begin
            step();
            if (bus.mem_en) begin
                if (prev_en == cyc - 1) consec++;
                prev_en = cyc;
                en_at[n_rdy] = cyc;
            end
            if (bus.if_ready) begin
                rdy_at[n_rdy] = cyc;
                rd_got[n_rdy] = bus.if_rdata;
                n_rdy++;
                if (n_rdy < 3) bus.if_addr = t6_addr[n_rdy];
                else           bus.if_req = 1'b0;
            end
        end
        chk("seq_ready_count", n_rdy, 32'd3);
        chk("seq_ready_gap1", rdy_at[1] - rdy_at[0], 32'd5);
        chk("seq_ready_gap2", rdy_at[2] - rdy_at[1], 32'd5);
        chk("seq_en_after_done1", en_at[1] - rdy_at[0], 32'd2);
        chk("seq_en_after_done2", en_at[2] - rdy_at[1], 32'd2);
        chk("seq_en_back_to_back", consec, 32'd0);
        for (int i = 0; i < 3; i++) chk("seq_rdata", rd_got[i], t6_data[i]);
        step();

        // random traffic against the timeline model
        rst = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        rd_due = -1;
        ref_mem = env_mem;
        free_at = 0; en_cyc = -1; rdy_cyc = -1; starve = 0;
        t_me = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        e_if_rd = '0; e_me_rd = '0; if_pend = 1'b0; me_pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            step();
            k = cyc;
            e_if_rdy = (k == rdy_cyc) && !t_me;
            e_me_rdy = (k == rdy_cyc) && t_me;
            if (k == rdy_cyc) begin
                if (t_me) begin
                    me_pend = 1'b0;
                    if (!t_we) e_me_rd = t_rdata;
                end else begin
                    if_pend = 1'b0;
                    e_if_rd = t_rdata;
                end
            end
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend     = 1'b1;
                bus.if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!me_pend && $urandom_range(0, 2) != 0) begin
                me_pend      = 1'b1;
                bus.me_we    = ($urandom_range(0, 2) == 0);
                bus.me_addr  = 32'($urandom_range(0, 15)) << 2;
                bus.me_wdata = $urandom();
            end
            bus.if_req = if_pend;
            bus.me_req = me_pend;
            #1;
            e_en = (k == en_cyc);
            chk("rnd_mem_en", bus.mem_en, e_en);
            chk("rnd_mem_we", bus.mem_we, e_en && t_we);
            if (e_en) chk("rnd_mem_addr", bus.mem_addr, t_addr);
            if (e_en && t_we) chk("rnd_mem_wdata", bus.mem_wdata, t_wdata);
            chk("rnd_if_ready", bus.if_ready, e_if_rdy);
            chk("rnd_me_ready", bus.me_ready, e_me_rdy);
            chk("rnd_if_rdata", bus.if_rdata, e_if_rd);
            chk("rnd_me_rdata", bus.me_rdata, e_me_rd);
            chk("rnd_pipe_stall", bus.pipe_stall,
                (if_pend && !e_if_rdy) || (me_pend && !e_me_rdy));
            // a new access may start only once the previous one has fully retired
            if (k >= free_at && (if_pend || me_pend)) begin
                t_me = me_pend && !(if_pend && starve == int'(STARVE_MAX));
                if (t_me && if_pend) starve = (starve < int'(STARVE_MAX)) ? starve + 1 : starve;
                else                 starve = 0;
                t_we    = t_me && bus.me_we;
                t_addr  = t_me ? bus.me_addr : bus.if_addr;
                t_wdata = bus.me_wdata;
                if (t_we) ref_mem[t_addr] = t_wdata;
                else      t_rdata = ref_mem.exists(t_addr) ? ref_mem[t_addr] : fill(t_addr);
                en_cyc  = k + 1;
                rdy_cyc = k + (t_we ? 2 : int'(LAT) + 2);
                free_at = rdy_cyc + 1;
            end
        end
        bus.if_req = 1'b0;
        bus.me_req = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
